// File: rtl/gemm_tile_sequencer.sv
// Tile-loop controller for the SNAX GEMM wrapper: walks m/n/k tiles, issues A/B reads and C writes.
// Optional performance counters are enabled by defining GEMM_TILE_SEQ_PERF_CNT_EN.
module gemm_tile_sequencer #(
  parameter int unsigned CntWidth   = 8,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned TileBytesA = 512,
  parameter int unsigned TileBytesB = 512,
  parameter int unsigned TileBytesC = 2048
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CntWidth-1:0]  m_i,
  input  logic [CntWidth-1:0]  n_i,
  input  logic [CntWidth-1:0]  k_i,
  input  logic [AddrWidth-1:0] base_a_i,
  input  logic [AddrWidth-1:0] base_b_i,
  input  logic [AddrWidth-1:0] base_c_i,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [AddrWidth-1:0] addr_a_o,
  output logic [AddrWidth-1:0] addr_b_o,
  input  logic                 acc_valid_i,
  output logic                 wr_valid_o,
  input  logic                 wr_ready_i,
  output logic [AddrWidth-1:0] addr_c_o,
  output logic                 busy_o,
  output logic                 done_o
`ifdef GEMM_TILE_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]          perf_cycles_o,
  output logic [31:0]          perf_rd_stall_o,
  output logic [31:0]          perf_wr_stall_o
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT_ACC,
    WRITE,
    DONE
  } state_e;

  // base + stride * (outer * dim + inner), all modulo 2^AddrWidth
  function automatic logic [AddrWidth-1:0] tile_addr(
    input logic [AddrWidth-1:0] base,
    input logic [AddrWidth-1:0] stride,
    input logic [CntWidth-1:0]  outer,
    input logic [CntWidth-1:0]  dim,
    input logic [CntWidth-1:0]  inner
  );
    tile_addr = base + stride * (AddrWidth'(outer) * AddrWidth'(dim) + AddrWidth'(inner));
  endfunction

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  m_q, n_q, k_q;
  logic [CntWidth-1:0]  m_cnt_q, n_cnt_q, k_cnt_q;
  logic [CntWidth-1:0]  m_cnt_d, n_cnt_d, k_cnt_d;
  logic [AddrWidth-1:0] base_a_q, base_b_q, base_c_q;
  logic [AddrWidth-1:0] addr_a_q, addr_b_q, addr_c_q;
  logic                 cfg_accept;
  logic                 addr_upd;
  logic                 last_k, last_n, last_m;

  // During config acceptance the new dimensions/bases are not yet registered.
  logic [CntWidth-1:0]  n_dim, k_dim;
  logic [AddrWidth-1:0] base_a_eff, base_b_eff, base_c_eff;

  assign cfg_accept = (state_q == IDLE) && cfg_valid_i;
  assign last_k     = (k_cnt_q == k_q - CntWidth'(1));
  assign last_n     = (n_cnt_q == n_q - CntWidth'(1));
  assign last_m     = (m_cnt_q == m_q - CntWidth'(1));

  assign n_dim      = cfg_accept ? n_i      : n_q;
  assign k_dim      = cfg_accept ? k_i      : k_q;
  assign base_a_eff = cfg_accept ? base_a_i : base_a_q;
  assign base_b_eff = cfg_accept ? base_b_i : base_b_q;
  assign base_c_eff = cfg_accept ? base_c_i : base_c_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    m_cnt_d  = m_cnt_q;
    n_cnt_d  = n_cnt_q;
    k_cnt_d  = k_cnt_q;
    addr_upd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          m_cnt_d  = '0;
          n_cnt_d  = '0;
          k_cnt_d  = '0;
          addr_upd = 1'b1;
          state_d  = ((m_i == '0) || (n_i == '0) || (k_i == '0)) ? DONE : READ;
        end
      end
      READ: begin
        if (rd_ready_i) state_d = WAIT_ACC;
      end
      WAIT_ACC: begin
        if (acc_valid_i) begin
          if (last_k) begin
            state_d = WRITE;
          end else begin
            k_cnt_d  = k_cnt_q + CntWidth'(1);
            addr_upd = 1'b1;
            state_d  = READ;
          end
        end
      end
      WRITE: begin
        if (wr_ready_i) begin
          k_cnt_d  = '0;
          addr_upd = 1'b1;
          if (last_n && last_m) begin
            state_d = DONE;
          end else if (last_n) begin
            n_cnt_d = '0;
            m_cnt_d = m_cnt_q + CntWidth'(1);
            state_d = READ;
          end else begin
            n_cnt_d = n_cnt_q + CntWidth'(1);
            state_d = READ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      m_cnt_q <= '0;
      n_cnt_q <= '0;
      k_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      m_cnt_q <= m_cnt_d;
      n_cnt_q <= n_cnt_d;
      k_cnt_q <= k_cnt_d;
    end
  end

  // Configuration holds its last values after a job ends.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
    end else if (cfg_accept) begin
      m_q      <= m_i;
      n_q      <= n_i;
      k_q      <= k_i;
      base_a_q <= base_a_i;
      base_b_q <= base_b_i;
      base_c_q <= base_c_i;
    end
  end

  // Addresses follow the next counter values so they are valid in the first request cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_c_q <= '0;
    end else if (addr_upd) begin
      addr_a_q <= tile_addr(base_a_eff, AddrWidth'(TileBytesA), m_cnt_d, k_dim, k_cnt_d);
      addr_b_q <= tile_addr(base_b_eff, AddrWidth'(TileBytesB), n_cnt_d, k_dim, k_cnt_d);
      addr_c_q <= tile_addr(base_c_eff, AddrWidth'(TileBytesC), m_cnt_d, n_dim, n_cnt_d);
    end
  end

  assign cfg_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign rd_valid_o  = (state_q == READ);
  assign wr_valid_o  = (state_q == WRITE);
  assign done_o      = (state_q == DONE);
  assign addr_a_o    = addr_a_q;
  assign addr_b_o    = addr_b_q;
  assign addr_c_o    = addr_c_q;

`ifdef GEMM_TILE_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles_q, perf_rd_stall_q, perf_wr_stall_q;

  // Saturating counters, cleared when a new job is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cycles_q   <= '0;
      perf_rd_stall_q <= '0;
      perf_wr_stall_q <= '0;
    end else if (cfg_accept) begin
      perf_cycles_q   <= '0;
      perf_rd_stall_q <= '0;
      perf_wr_stall_q <= '0;
    end else begin
      if (busy_o && (perf_cycles_q != '1))
        perf_cycles_q <= perf_cycles_q + 32'd1;
      if (rd_valid_o && !rd_ready_i && (perf_rd_stall_q != '1))
        perf_rd_stall_q <= perf_rd_stall_q + 32'd1;
      if (wr_valid_o && !wr_ready_i && (perf_wr_stall_q != '1))
        perf_wr_stall_q <= perf_wr_stall_q + 32'd1;
    end
  end

  assign perf_cycles_o   = perf_cycles_q;
  assign perf_rd_stall_o = perf_rd_stall_q;
  assign perf_wr_stall_o = perf_wr_stall_q;
`else
  // Default build: no performance counters.
`endif

endmodule
